rx_deframer: RTL

RX_DEFRAMER -- requirements
Module: rx_deframer

---
 rtl/rx_deframer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/rx_deframer.sv
// rx_deframer: UART receive deframer with majority-voted sampling and a one-frame holding register
module rx_deframer #(
  parameter int ACC_WIDTH     = 16,
  parameter int MAX_DATA_BITS = 9
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [ACC_WIDTH-1:0]     cr_acc_incr_i,
  input  logic [3:0]               cr_dbits_i,
  input  logic [1:0]               cr_p_i,
  input  logic                     cr_s_i,
  input  logic                     uart_rx_i,
  input  logic                     ready_i,
  output logic [MAX_DATA_BITS-1:0] data_o,
  output logic                     valid_o,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     break_o,
  output logic                     overrun_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_t;
  state_t                   r_state, w_nxt;
  logic [1:0]               r_sync, r_hist;
  logic [ACC_WIDTH-1:0]     r_acc;
  logic [3:0]               r_cnt;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic                     r_par, r_zero, r_perr, r_ferr, r_brk, r_done;
  logic                     w_line, w_half, w_tick, w_last_data, w_last_stop, w_pub, w_load;
  logic [ACC_WIDTH:0]       w_sum;
  logic [3:0]               w_dbits;
  logic [MAX_DATA_BITS-1:0] w_bit;
  assign w_line      = (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);
  assign w_sum       = {1'b0, r_acc} + {1'b0, cr_acc_incr_i};
  assign w_half      = |w_sum[ACC_WIDTH:ACC_WIDTH-1];
  assign w_tick      = w_sum[ACC_WIDTH];
  assign w_dbits     = (cr_dbits_i < 4'd5) ? 4'd5 :
                       (cr_dbits_i > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) : cr_dbits_i;
  assign w_last_data = r_cnt >= w_dbits - 4'd1;
  assign w_last_stop = !cr_s_i || r_cnt != 4'd0;
  assign w_bit       = MAX_DATA_BITS'(1) << r_cnt;
  assign w_pub       = (r_state == S_STOP) && r_done;
  assign w_load      = w_pub && (!valid_o || ready_i);
  // two-flop synchronizer followed by a 3-sample history for the majority vote
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= 2'b11;
      r_hist <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], uart_rx_i};
      r_hist <= {r_hist[0], r_sync[1]};
    end
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else r_state <= w_nxt;
  end
  // next-state logic; STOP lingers one extra cycle (r_done) to publish the frame
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     w_nxt = w_line ? S_IDLE : S_START;
      S_START:    if (w_half) w_nxt = w_line ? S_IDLE : S_DATA;
      S_DATA:     if (w_tick && w_last_data) w_nxt = (cr_p_i != 2'b00) ? S_PARITY : S_STOP;
      S_PARITY:   if (w_tick) w_nxt = S_STOP;
      S_STOP:     if (r_done) w_nxt = r_brk ? S_BRK_WAIT : S_IDLE;
      S_BRK_WAIT: if (w_line) w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end
  // baud accumulator, bit counter and per-frame shift/status collection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_zero  <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_brk   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_START: begin
          r_acc <= w_half ? '0 : w_sum[ACC_WIDTH-1:0];
          if (w_half) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_zero  <= 1'b1;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_brk   <= 1'b0;
          end
        end
        S_DATA: begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          if (w_tick) begin
            r_shift <= w_line ? (r_shift | w_bit) : r_shift;
            r_par   <= r_par ^ w_line;
            r_zero  <= r_zero & !w_line;
            r_cnt   <= w_last_data ? 4'd0 : r_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          if (w_tick) begin
            r_perr <= (r_par ^ w_line) != (cr_p_i == 2'b01);
            r_zero <= r_zero & !w_line;
          end
        end
        S_STOP: begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          if (r_done) r_done <= 1'b0;
          else if (w_tick) begin
            r_ferr <= r_ferr | !w_line;
            r_brk  <= (r_cnt == 4'd0) ? (r_zero & !w_line) : r_brk;
            r_cnt  <= r_cnt + 4'd1;
            r_done <= w_last_stop;
          end
        end
        default: begin
          r_acc  <= '0;
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
      endcase
    end
  end
  // holding register: publish when free or being accepted, otherwise flag overrun
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      if (w_load) begin
        data_o       <= r_shift;
        parity_err_o <= r_perr;
        frame_err_o  <= r_ferr;
        break_o      <= r_brk;
        valid_o      <= 1'b1;
      end else if (valid_o && ready_i) valid_o <= 1'b0;
      if (w_pub && !w_load) overrun_o <= 1'b1;
      else if (valid_o && ready_i) overrun_o <= 1'b0;
    end
  end
endmodule
